// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared types and defaults for the data-side memory path
package mips_mem_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic {RUN, FLUSH} sb_state_t;
  localparam int SB_DEPTH_DEFAULT = 4;
  function automatic logic same_word(word_t a, word_t b);
    return a[31:2] == b[31:2];
  endfunction
endpackage

// File: rtl/harvard_store_buffer_if.sv
// harvard_store_buffer_if: CPU-side and data-RAM-side signals of the store buffer
interface harvard_store_buffer_if;
  import mips_mem_pkg::*;
  word_t cpu_address;
  logic cpu_write;
  logic cpu_read;
  word_t cpu_writedata;
  word_t cpu_readdata;
  logic cpu_stall;
  logic flush;
  word_t mem_address;
  logic mem_write;
  logic mem_read;
  word_t mem_writedata;
  word_t mem_readdata;
  logic [4:0] count;
  logic empty;
  modport slave (
    input cpu_address, cpu_write, cpu_read, cpu_writedata, flush, mem_readdata,
    output cpu_readdata, cpu_stall, mem_address, mem_write, mem_read, mem_writedata, count, empty
  );
  modport master (
    output cpu_address, cpu_write, cpu_read, cpu_writedata, flush, mem_readdata,
    input cpu_readdata, cpu_stall, mem_address, mem_write, mem_read, mem_writedata, count, empty
  );
endinterface

// File: rtl/harvard_sb_fifo.sv
// harvard_sb_fifo: circular store storage with wrap-bit pointers; entries exposed for forwarding
module harvard_sb_fifo import mips_mem_pkg::*; #(
  parameter int DEPTH = SB_DEPTH_DEFAULT,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic push,
  input  logic pop,
  input  word_t push_addr,
  input  word_t push_data,
  output word_t addr_q [DEPTH],
  output word_t data_q [DEPTH],
  output logic [AW-1:0] head,
  output logic [4:0] count
);
  logic [AW:0] wr_ptr, rd_ptr, diff;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  // storage survives reset; only the pointers decide what is valid
  always_ff @(posedge clk)
    if (push) begin
      addr_q[wr_ptr[AW-1:0]] <= push_addr;
      data_q[wr_ptr[AW-1:0]] <= push_data;
    end
  assign diff = wr_ptr - rd_ptr;
  assign head = rd_ptr[AW-1:0];
  assign count = 5'(diff);
endmodule

// File: rtl/harvard_store_buffer.sv
// harvard_store_buffer: store buffer between CPU and data RAM with load forwarding,
// load-first port arbitration and a RUN/FLUSH drain FSM
module harvard_store_buffer import mips_mem_pkg::*; #(
  parameter int DEPTH = SB_DEPTH_DEFAULT
) (
  input logic clk,
  input logic reset_n,
  harvard_store_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  word_t addr_q [DEPTH];
  word_t data_q [DEPTH];
  word_t fwd_data;
  logic [AW-1:0] head;
  logic [4:0] count;
  sb_state_t state;
  logic in_flush, full, rd_req, push, pop, hit;
  harvard_sb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk), .reset_n(reset_n), .push(push), .pop(pop),
    .push_addr(bus.cpu_address), .push_data(bus.cpu_writedata),
    .addr_q(addr_q), .data_q(data_q), .head(head), .count(count)
  );
  assign in_flush = state == FLUSH;
  assign full = count == 5'(DEPTH);
  assign rd_req = bus.cpu_read & ~bus.cpu_write & ~in_flush;
  assign push = bus.cpu_write & ~in_flush & ~full;
  // any cpu_read holds the port, even alongside a write, so stores can be parked
  assign pop = (count != 5'd0) & (in_flush | ~bus.cpu_read);
  // scanning oldest to youngest lets the youngest match win
  always_comb begin
    hit = 1'b0;
    fwd_data = '0;
    for (int k = 0; k < DEPTH; k++)
      if (5'(k) < count && same_word(addr_q[head + AW'(k)], bus.cpu_address)) begin
        hit = 1'b1;
        fwd_data = data_q[head + AW'(k)];
      end
  end
  assign bus.mem_read = reset_n & rd_req & ~hit;
  assign bus.mem_write = pop;
  assign bus.mem_address = bus.mem_read ? bus.cpu_address : addr_q[head];
  assign bus.mem_writedata = data_q[head];
  assign bus.cpu_readdata = hit ? fwd_data : bus.mem_readdata;
  assign bus.cpu_stall = in_flush ? (bus.cpu_read | bus.cpu_write) : (bus.cpu_write & full);
  assign bus.count = count;
  assign bus.empty = count == 5'd0;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= RUN;
    else state <= in_flush ? (count <= 5'd1 ? RUN : FLUSH) : (bus.flush ? FLUSH : RUN);
endmodule
